// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryption engine.
//
// Runs ROUNDS_PER_CYCLE chained cipher rounds per clock. The round keys are
// expanded on the fly next to the datapath, so only the current state and
// the current round key are stored. One block is in flight at a time.
// ROUNDS_PER_CYCLE must be 1, 2, 5 or 10; the latency from the acceptance
// edge to the edge that raises out_valid is 10 / ROUNDS_PER_CYCLE cycles.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   in_valid        plaintext/key valid
//   in_ready        engine can accept a block (tracks out_ready while DONE)
//   in_plaintext    128-bit plaintext, byte 0 at [127:120]
//   in_key          128-bit cipher key, byte 0 at [127:120]
//   out_valid       ciphertext valid; held until out_ready is sampled high
//   out_ready       consumer accepts the ciphertext
//   out_ciphertext  128-bit ciphertext; keeps its value after out_valid falls
module aes128_iter_encrypt #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_plaintext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ciphertext
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  // First round number of the cycle that finishes round 10.
  localparam logic [3:0] LastRnd = 4'(11 - ROUNDS_PER_CYCLE);
  localparam logic [3:0] RndStep = 4'(ROUNDS_PER_CYCLE);

  // S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Derives round key rnd from round key rnd-1.
  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rcon(rnd), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3, b0, b1, b2, b3;
    logic [127:0] mc;
    for (int n = 0; n < 16; n++) begin
      sb[n] = sbox(st[127 - 8 * n -: 8]);
    end
    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
      end
    end
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4 * c];
      a1 = sr[4 * c + 1];
      a2 = sr[4 * c + 2];
      a3 = sr[4 * c + 3];
      if (last) begin
        b0 = a0;
        b1 = a1;
        b2 = a2;
        b3 = a3;
      end else begin
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      mc[127 - 32 * c -: 32] = {b0, b1, b2, b3};
    end
    return mc ^ rk;
  endfunction

  // Chains ROUNDS_PER_CYCLE rounds starting at round rnd; returns {state, key}.
  function automatic logic [255:0] run_rounds(input logic [127:0] st, input logic [127:0] key,
                                              input logic [3:0] rnd);
    logic [127:0] s_v, k_v;
    logic [3:0]   r_v;
    s_v = st;
    k_v = key;
    for (int i = 0; i < int'(ROUNDS_PER_CYCLE); i++) begin
      r_v = rnd + 4'(i);
      k_v = expand_key(k_v, r_v);
      s_v = aes_round(s_v, k_v, r_v == 4'd10);
    end
    return {s_v, k_v};
  endfunction

  state_e       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_key, r_ct;
  logic [3:0]   r_rnd;
  logic [127:0] w_nxt_state, w_nxt_key;
  logic         w_last, w_accept;

  always_comb begin
    {w_nxt_state, w_nxt_key} = run_rounds(r_state, r_key, r_rnd);
  end

  assign w_last   = (r_rnd == LastRnd);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= StIdle;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_fsm)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = StRun;
      end
      StRun: begin
        if (w_last) w_fsm_nxt = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        // Accepting in the same cycle as the output handshake avoids a bubble.
        in_ready  = out_ready;
        if (out_ready) w_fsm_nxt = in_valid ? StRun : StIdle;
      end
      default: w_fsm_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
      r_ct    <= '0;
    end else if (w_accept) begin
      r_state <= in_plaintext ^ in_key;
      r_key   <= in_key;
      r_rnd   <= 4'd1;
    end else if (r_fsm == StRun) begin
      r_state <= w_nxt_state;
      r_key   <= w_nxt_key;
      r_rnd   <= r_rnd + RndStep;
      if (w_last) r_ct <= w_nxt_state;
    end
  end

  assign out_ciphertext = r_ct;

endmodule

// File: doc/aes128_iter_encrypt.md
Name: aes128_iter_encrypt

Overview:
Iterative AES-128 encryption engine that reuses one or more combinational round stages over several clock cycles. It computes the key schedule on the fly and takes one plaintext/key pair per handshake. It generalises the single combinational round to a full 10-round cipher, with a parameterised unroll factor (rounds per cycle), valid/ready flow control and output back-pressure. It sits between the key/data input interface and the ciphertext consumer.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds evaluated per clock. Legal values are 1, 2, 5 and 10; any other value is a elaboration-time error.

Ports:
clk  input  1  clock; all logic is rising-edge triggered
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext and key are valid
in_ready  output  1  engine can accept a new block
in_plaintext  input  128  plaintext; byte 0 is at [127:120], FIPS-197 column-major order
in_key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext is valid
out_ready  input  1  consumer accepts the ciphertext
out_ciphertext  output  128  ciphertext, same byte order

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_ciphertext=0; round counter=0; internal state and key registers=0.
- State machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On the handshake (in_valid && in_ready), register state <= in_plaintext ^ in_key (initial AddRoundKey) and round key <= in_key.
  - Set rnd=1 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, apply ROUNDS_PER_CYCLE chained stages, for r = rnd .. rnd+ROUNDS_PER_CYCLE-1:
    - Expand the next round key: w[i] = w[i-4] ^ (i%4==0 ? SubWord(RotWord(w[i-1])) ^ Rcon[r] : w[i-1]). Rcon = 01,02,04,08,10,20,40,80,1b,36.
    - Apply SubBytes, then ShiftRows, then MixColumns (MixColumns is skipped when r==10), then AddRoundKey.
  - rnd advances by ROUNDS_PER_CYCLE each cycle.
  - When the cycle that completes round 10 ends, load out_ciphertext, set out_valid=1 and go to DONE.
- Latency: exactly 10/ROUNDS_PER_CYCLE cycles from the acceptance edge to the edge that raises out_valid. That is 10, 5, 2 or 1 cycles.
- DONE:
  - out_valid=1. out_ciphertext is held stable until out_ready is sampled high.
  - in_ready = out_ready, combinational, so a new block can be accepted in the same cycle as the output handshake.
  - Output handshake with no new input: clear out_valid and go to IDLE.
  - Output handshake with a simultaneous input handshake: load the new block, clear out_valid and go to RUN. No bubble cycle occurs.
- Inputs are ignored whenever in_ready=0. in_plaintext and in_key are sampled only on the acceptance edge and may change afterwards.
- out_ciphertext keeps its last value after out_valid falls.
- rst asserted in any state, including mid-RUN or DONE with out_valid high, returns all registers to their reset values on the next edge. The in-flight block is discarded and no out_valid is produced for it.
- All arithmetic is GF(2^8) with reduction polynomial 0x11b. The S-box is a constant lookup table.

Test Plan:
1. FIPS-197 App. B, ROUNDS_PER_CYCLE=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid rises exactly 10 cycles after acceptance with ct 3925841d02dc09fbdc118597196a0b32. Internal state after round 1 = a49c7ff2689f352b6b5bea43026a5049, after round 2 = aa8f5f0361dde3ef82d24ad26832469a.
2. FIPS-197 App. C.1, at each of ROUNDS_PER_CYCLE = 1, 2, 5 and 10: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, with latency 10, 5, 2 and 1 cycles respectively.
3. Back-pressure: hold out_ready=0 for 20 cycles after out_valid rises -> ciphertext stays stable, in_ready stays 0, and in_valid pulses are ignored. Then raise out_ready for one cycle -> out_valid falls and the engine returns to IDLE.
4. Back-to-back: in_valid held high with vector B queued and out_ready=1 -> vector B is accepted on the same edge that vector A's output is consumed. Vector B's result appears exactly 10/ROUNDS_PER_CYCLE cycles later.
5. Reset mid-operation: assert rst at cycle 4 of RUN -> the next cycle shows in_ready=1, out_valid=0 and out_ciphertext=0. Issuing App. B again afterwards produces the correct ciphertext.
6. Input change after acceptance: change in_plaintext and in_key on the cycle after the handshake -> the result still equals the ciphertext for the originally sampled plaintext and key.
